// File: rtl/aes_ct_collector.sv
// aes_ct_collector: captures cipher blocks strobed by the AES engine, tags them
// with block index / message id, buffers them in a show-ahead FIFO and replays
// them on a valid/ready stream. Blocks arriving while full are dropped and
// flagged on the sticky o_overflow.
// Optional build macro: CT_BYTE_SWAP_EN -- byte-reverse o_data on output.
module aes_ct_collector #(
  parameter int DEPTH    = 8,
  parameter int BYPASS_W = 289,
  parameter int ID_W     = 8,
  localparam int AW      = $clog2(DEPTH),
  localparam int PW      = AW + 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                i_ct_valid,
  input  logic [127:0]        i_cipher_text,
  input  logic [BYPASS_W-1:0] i_bypass_text,
  input  logic                i_ct_last,
  output logic                o_valid,
  input  logic                i_ready,
  output logic [127:0]        o_data,
  output logic [BYPASS_W-1:0] o_bypass,
  output logic                o_last,
  output logic [15:0]         o_blk_idx,
  output logic [ID_W-1:0]     o_msg_id,
  output logic [PW-1:0]       o_level,
  output logic                o_overflow
);

  typedef struct packed {
    logic [127:0]        data;
    logic [BYPASS_W-1:0] byp;
    logic                last;
    logic [15:0]         idx;
    logic [ID_W-1:0]     id;
  } ent_t;

  ent_t            mem [DEPTH];
  ent_t            head;
  logic [PW-1:0]   wptr, rptr;
  logic [15:0]     wr_idx;
  logic [ID_W-1:0] wr_id;
  logic [1:0]      rst_sync;
  logic            run, empty, full, pop, push;

  // Reset release synchronizer; strobes are ignored until it has settled.
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) rst_sync <= 2'b00;
    else          rst_sync <= {rst_sync[0], 1'b1};

  assign run   = rst_sync[1];
  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign pop   = !empty && i_ready;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign push  = run && i_ct_valid && (!full || pop);

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk)
    if (push) mem[wptr[AW-1:0]] <= '{data: i_cipher_text, byp: i_bypass_text,
                                     last: i_ct_last, idx: wr_idx, id: wr_id};

  // Pointers, write-side tags and sticky overflow.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr       <= '0;
      rptr       <= '0;
      wr_idx     <= '0;
      wr_id      <= '0;
      o_overflow <= 1'b0;
    end else begin
      if (pop) rptr <= rptr + 1'b1;
      if (push) begin
        wptr <= wptr + 1'b1;
        if (i_ct_last) begin
          wr_idx <= '0;
          wr_id  <= wr_id + 1'b1;
        end else if (wr_idx != 16'hFFFF) begin
          wr_idx <= wr_idx + 1'b1;
        end
      end else if (run && i_ct_valid) begin
        o_overflow <= 1'b1;
      end
    end
  end

  // Show-ahead head read.
  assign head      = mem[rptr[AW-1:0]];
  assign o_valid   = !empty;
  assign o_level   = wptr - rptr;
  assign o_bypass  = head.byp;
  assign o_last    = head.last;
  assign o_blk_idx = head.idx;
  assign o_msg_id  = head.id;

`ifdef CT_BYTE_SWAP_EN
  // Byte k of the stored block appears at byte 15-k of o_data.
  for (genvar k = 0; k < 16; k++) begin : g_swap
    assign o_data[8*k +: 8] = head.data[8*(15-k) +: 8];
  end
`else
  assign o_data = head.data;
`endif

endmodule

// File: tb/tb_aes_ct_collector.sv
// Self-checking bench for aes_ct_collector: directed table, hand-written
// corner sequences, and random traffic against a queue-based reference.
module tb_aes_ct_collector;
  localparam int DEPTH = 8, BW = 289, IW = 8;

  logic           clk = 1'b0, reset_n = 1'b0;
  logic           i_ct_valid = 1'b0, i_ct_last = 1'b0, i_ready = 1'b0;
  logic [127:0]   i_cipher_text = '0;
  logic [BW-1:0]  i_bypass_text = '0;
  logic           o_valid, o_last, o_overflow;
  logic [127:0]   o_data;
  logic [BW-1:0]  o_bypass;
  logic [15:0]    o_blk_idx;
  logic [IW-1:0]  o_msg_id;
  logic [3:0]     o_level;

  aes_ct_collector #(.DEPTH(DEPTH), .BYPASS_W(BW), .ID_W(IW)) dut (
    .clk(clk), .reset_n(reset_n), .i_ct_valid(i_ct_valid),
    .i_cipher_text(i_cipher_text), .i_bypass_text(i_bypass_text),
    .i_ct_last(i_ct_last), .o_valid(o_valid), .i_ready(i_ready),
    .o_data(o_data), .o_bypass(o_bypass), .o_last(o_last),
    .o_blk_idx(o_blk_idx), .o_msg_id(o_msg_id), .o_level(o_level),
    .o_overflow(o_overflow));

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [511:0] got, input logic [511:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  function automatic logic [127:0] bswap(input logic [127:0] x);
    logic [127:0] r;
    for (int k = 0; k < 16; k++) r[8*k +: 8] = x[8*(15-k) +: 8];
    return r;
  endfunction

  function automatic logic [127:0] exp_data(input logic [127:0] x);
`ifdef CT_BYTE_SWAP_EN
    return bswap(x);
`else
    return x;
`endif
  endfunction

  // Reference model: a plain queue of tagged blocks plus message counters.
  typedef struct {
    logic [127:0]  data;
    logic [BW-1:0] byp;
    logic          last;
    int            idx;
    int            id;
  } ent_t;
  ent_t q[$];
  int   m_idx, m_id;
  bit   m_ovf;

  task automatic model_clear();
    q.delete(); m_idx = 0; m_id = 0; m_ovf = 0;
  endtask

  task automatic check_model();
    chk("valid", 512'(o_valid), 512'(q.size() > 0));
    chk("level", 512'(o_level), 512'(q.size()));
    chk("overflow", 512'(o_overflow), 512'(m_ovf));
    if (q.size() > 0) begin
      chk("data", 512'(o_data), 512'(exp_data(q[0].data)));
      chk("bypass", 512'(o_bypass), 512'(q[0].byp));
      chk("last", 512'(o_last), 512'(q[0].last));
      chk("blk_idx", 512'(o_blk_idx), 512'(q[0].idx));
      chk("msg_id", 512'(o_msg_id), 512'(q[0].id));
    end
  endtask

  // One clock with the current inputs; model follows, then outputs are checked.
  task automatic tick();
    bit pop, acc;
    ent_t e;
    pop = (q.size() > 0) && i_ready;
    acc = i_ct_valid && ((q.size() < DEPTH) || pop);
    @(posedge clk); #1;
    if (pop) void'(q.pop_front());
    if (acc) begin
      e.data = i_cipher_text; e.byp = i_bypass_text; e.last = i_ct_last;
      e.idx = m_idx; e.id = m_id;
      q.push_back(e);
      if (i_ct_last) begin m_idx = 0; m_id = (m_id + 1) % 256; end
      else if (m_idx < 65535) m_idx++;
    end else if (i_ct_valid) m_ovf = 1;
    check_model();
  endtask

  task automatic drive(input bit v, input logic [127:0] d, input bit l, input bit r);
    logic [319:0] t;
    t = {$urandom, $urandom, $urandom, $urandom, $urandom,
         $urandom, $urandom, $urandom, $urandom, $urandom};
    i_ct_valid = v; i_cipher_text = d; i_ct_last = l; i_ready = r;
    i_bypass_text = t[BW-1:0];
  endtask

  task automatic do_reset();
    drive(0, '0, 0, 0);
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_clear();
    chk("rst_valid", 512'(o_valid), 512'(0));
    chk("rst_level", 512'(o_level), 512'(0));
    chk("rst_ovf", 512'(o_overflow), 512'(0));
    @(negedge clk) reset_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
  endtask

  typedef struct {
    bit v; bit l; bit r; logic [127:0] d;
    bit ev; int elev; int eidx; bit elast; int eid;
  } vec_t;

  initial begin
    vec_t vt[6];
    vt[0] = '{1, 0, 1, 128'h01, 1, 1, 0, 0, 0};
    vt[1] = '{1, 0, 1, 128'h02, 1, 1, 1, 0, 0};
    vt[2] = '{1, 1, 1, 128'h03, 1, 1, 2, 1, 0};
    vt[3] = '{0, 0, 1, 128'h00, 0, 0, 0, 0, 0};
    vt[4] = '{1, 1, 1, 128'h04, 1, 1, 0, 1, 1};
    vt[5] = '{0, 0, 1, 128'h00, 0, 0, 0, 0, 0};

    do_reset();

    // Single message then a second message, table-driven.
    foreach (vt[i]) begin
      drive(vt[i].v, vt[i].d, vt[i].l, vt[i].r);
      tick();
      chk($sformatf("tbl%0d_valid", i), 512'(o_valid), 512'(vt[i].ev));
      chk($sformatf("tbl%0d_level", i), 512'(o_level), 512'(vt[i].elev));
      if (vt[i].ev) begin
        chk($sformatf("tbl%0d_data", i), 512'(o_data), 512'(exp_data(vt[i].d)));
        chk($sformatf("tbl%0d_idx", i), 512'(o_blk_idx), 512'(vt[i].eidx));
        chk($sformatf("tbl%0d_last", i), 512'(o_last), 512'(vt[i].elast));
        chk($sformatf("tbl%0d_id", i), 512'(o_msg_id), 512'(vt[i].eid));
      end
    end

    // Byte-order check on a known block, held under backpressure.
    drive(1, 128'hD9313225F88406E5A55909C5AFF5269A, 0, 0); tick();
    drive(0, '0, 0, 0); tick();
`ifdef CT_BYTE_SWAP_EN
    chk("bswap", 512'(o_data), 512'(128'h9A26F5AFC50959A5E50684F8253231D9));
`else
    chk("bswap", 512'(o_data), 512'(128'hD9313225F88406E5A55909C5AFF5269A));
`endif

    // Backpressure: DEPTH+1 strobes, ninth dropped.
    do_reset();
    for (int k = 1; k <= DEPTH + 1; k++) begin drive(1, 128'(k), 0, 0); tick(); end
    chk("bp_level", 512'(o_level), 512'(8));
    chk("bp_ovf", 512'(o_overflow), 512'(1));
    for (int k = 1; k <= DEPTH; k++) begin
      chk("bp_drain_data", 512'(o_data), 512'(exp_data(128'(k))));
      drive(0, '0, 0, 1); tick();
    end
    chk("bp_empty", 512'(o_valid), 512'(0));
    drive(1, 128'h99, 0, 0); tick();
    chk("bp_next_idx", 512'(o_blk_idx), 512'(8));

    // Full with a simultaneous pop: no overflow, level steady.
    do_reset();
    for (int k = 0; k < DEPTH; k++) begin drive(1, 128'(k + 16), 0, 0); tick(); end
    drive(1, 128'hAA, 0, 1); tick();
    chk("fullpop_level", 512'(o_level), 512'(8));
    chk("fullpop_ovf", 512'(o_overflow), 512'(0));

    // Async reset mid-burst with 5 entries buffered and overflow set.
    drive(1, 128'hBB, 0, 0); tick();
    for (int k = 0; k < 3; k++) begin drive(0, '0, 0, 1); tick(); end
    drive(0, '0, 0, 0);
    chk("pre_rst_level", 512'(o_level), 512'(5));
    #2 reset_n = 1'b0;
    #1;
    chk("async_valid", 512'(o_valid), 512'(0));
    chk("async_level", 512'(o_level), 512'(0));
    chk("async_ovf", 512'(o_overflow), 512'(0));
    do_reset();
    drive(1, 128'hCC, 1, 0); tick();
    chk("post_rst_id", 512'(o_msg_id), 512'(0));
    chk("post_rst_idx", 512'(o_blk_idx), 512'(0));

    // Id wrap over 257 single-block messages.
    do_reset();
    for (int k = 0; k <= 256; k++) begin
      drive(1, 128'(k), 1, 1); tick();
      if (k == 255 || k == 256)
        chk($sformatf("wrap_id%0d", k), 512'(o_msg_id), 512'(k % 256));
    end

    // Random traffic against the reference model.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      drive($urandom_range(0, 9) < 6, {$urandom, $urandom, $urandom, $urandom},
            $urandom_range(0, 3) == 0, $urandom_range(0, 9) < (n % 400 < 200 ? 7 : 3));
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
